// File: rtl/pulse_spacer_pkg.sv
// Shared definitions for the pulse spacer: FSM state encodings and a
// constant-evaluable ceil(log2) helper used to size internal counters.
package pulse_spacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Bounded loop so it stays usable in localparam expressions; never returns 0.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_spacer_sat_updown_cnt.sv
// Saturating up/down counter holding the number of queued events.
// Simultaneous inc and dec cancel; the count never wraps in either direction.
module sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic         clk_src,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full
);

    localparam logic [W-1:0] MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == MAX);

endmodule

// File: rtl/pulse_spacer.sv
// Queues single-cycle source events and re-issues them as pulses spaced at
// least GAP cycles apart, ahead of a toggle pulse synchronizer.
module pulse_spacer
    import pulse_spacer_pkg::*;
#(
    parameter int GAP   = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_src,
    input  logic             rst_n,
    input  logic             event_in,
    input  logic             en,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam int               GAP_W      = clog2(GAP);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 2);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             pulse_q, pulse_d;
    logic             ovf_q, ovf_d;
    logic             can_fire, inc, dec, full;

    // FIRE plus GAP-1 WAIT cycles puts consecutive pulses exactly GAP apart.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        can_fire = (pending != '0) && en;
        case (state_q)
            ST_IDLE: begin
                if (can_fire) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
                gap_d   = GAP_RELOAD;
            end
            ST_WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_ONE;
                end else if (can_fire) begin
                    state_d = ST_FIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // FIRE never follows FIRE, so this marks the transition into FIRE.
        dec     = (state_d == ST_FIRE);
        inc     = event_in && !(full && !dec);
        pulse_d = dec;

        ovf_d = ovf_q;
        if (event_in && full && !dec) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    sat_updown_cnt #(
        .W(CNT_W)
    ) u_pending (
        .clk_src (clk_src),
        .rst_n   (rst_n),
        .inc     (inc),
        .dec     (dec),
        .cnt     (pending),
        .full    (full)
    );

    assign pulse_out = pulse_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != ST_IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_spacer.sv
// Self-checking bench for pulse_spacer: three instances (GAP/CNT_W of 4/4, 4/2, 2/4)
// share one stimulus stream and are each compared against a timing-rule model.
module tb_pulse_spacer;

    logic clk_src = 1'b0;
    always #5 clk_src = ~clk_src;

    logic rst_n, event_in, en, clr_ovf;

    logic       pulse_a, busy_a, ovf_a;
    logic [3:0] pend_a;
    logic       pulse_b, busy_b, ovf_b;
    logic [1:0] pend_b;
    logic       pulse_c, busy_c, ovf_c;
    logic [3:0] pend_c;

    pulse_spacer #(.GAP(4), .CNT_W(4)) dut_a (
        .clk_src(clk_src), .rst_n(rst_n), .event_in(event_in), .en(en), .clr_ovf(clr_ovf),
        .pulse_out(pulse_a), .pending(pend_a), .busy(busy_a), .overflow(ovf_a));

    pulse_spacer #(.GAP(4), .CNT_W(2)) dut_b (
        .clk_src(clk_src), .rst_n(rst_n), .event_in(event_in), .en(en), .clr_ovf(clr_ovf),
        .pulse_out(pulse_b), .pending(pend_b), .busy(busy_b), .overflow(ovf_b));

    pulse_spacer #(.GAP(2), .CNT_W(4)) dut_c (
        .clk_src(clk_src), .rst_n(rst_n), .event_in(event_in), .en(en), .clr_ovf(clr_ovf),
        .pulse_out(pulse_c), .pending(pend_c), .busy(busy_c), .overflow(ovf_c));

    int errors = 0;
    int checks = 0;

    // Reference model: a pulse may be issued next cycle when enabled, something is
    // queued and at least GAP cycles will have passed since the previous pulse.
    int gap_p[3] = '{4, 4, 2};
    int max_p[3] = '{15, 3, 15};
    int m_pend[3], m_since[3], m_ovf[3], m_pulse[3], m_acc[3];

    typedef struct {
        logic ev;
        logic en;
        logic clr;
        int   exp_pulse;
        int   exp_pend;
        int   exp_busy;
        int   exp_ovf;
    } vec_t;

    vec_t vecs[21];

    task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i]  = 0;
            m_ovf[i]   = 0;
            m_pulse[i] = 0;
            m_since[i] = 1000;
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            int fire, acc;
            fire = (en && m_pend[i] > 0 && m_since[i] >= gap_p[i] - 1) ? 1 : 0;
            acc  = (event_in && (m_pend[i] < max_p[i] || fire == 1)) ? 1 : 0;
            if (event_in && acc == 0) m_ovf[i] = 1;
            else if (clr_ovf) m_ovf[i] = 0;
            m_pend[i]  = m_pend[i] + acc - fire;
            m_acc[i]   = m_acc[i] + acc;
            m_pulse[i] = fire;
            m_since[i] = (fire == 1) ? 0 : ((m_since[i] < 1000) ? m_since[i] + 1 : 1000);
        end
    endtask

    function automatic int modelBusy(input int i);
        return (m_pend[i] > 0 || m_since[i] < gap_p[i]) ? 1 : 0;
    endfunction

    task automatic compareModel();
        checkOutput("mdl_a.pulse",   32'(pulse_a), m_pulse[0]);
        checkOutput("mdl_a.pending", 32'(pend_a),  m_pend[0]);
        checkOutput("mdl_a.busy",    32'(busy_a),  modelBusy(0));
        checkOutput("mdl_a.ovf",     32'(ovf_a),   m_ovf[0]);
        checkOutput("mdl_b.pulse",   32'(pulse_b), m_pulse[1]);
        checkOutput("mdl_b.pending", 32'(pend_b),  m_pend[1]);
        checkOutput("mdl_b.busy",    32'(busy_b),  modelBusy(1));
        checkOutput("mdl_b.ovf",     32'(ovf_b),   m_ovf[1]);
        checkOutput("mdl_c.pulse",   32'(pulse_c), m_pulse[2]);
        checkOutput("mdl_c.pending", 32'(pend_c),  m_pend[2]);
        checkOutput("mdl_c.busy",    32'(busy_c),  modelBusy(2));
        checkOutput("mdl_c.ovf",     32'(ovf_c),   m_ovf[2]);
    endtask

    // Inputs are held for one clock, then outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic ev, input logic e, input logic clr);
        event_in = ev;
        en       = e;
        clr_ovf  = clr;
        modelStep();
        @(posedge clk_src);
        #1;
        compareModel();
    endtask

    initial begin
        int pulses, last, bad, acc_before, n;

        // Rows: inputs during cycle i, dut_a outputs expected in cycle i+1.
        // Rows 0-6: single event. Rows 7-20: events on three consecutive cycles.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 0, 1, 1, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1, 0, 1, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 0, 1, 1, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1, 1, 1, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 0, 2, 1, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 0, 2, 1, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 0, 2, 1, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1, 1, 1, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1, 0, 1, 0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0};

        for (int i = 0; i < 3; i++) m_acc[i] = 0;
        rst_n    = 1'b0;
        event_in = 1'b0;
        en       = 1'b1;
        clr_ovf  = 1'b0;
        modelReset();
        @(posedge clk_src);
        @(posedge clk_src);
        #1;
        checkOutput("reset.pulse",   32'(pulse_a), 0);
        checkOutput("reset.pending", 32'(pend_a),  0);
        checkOutput("reset.busy",    32'(busy_a),  0);
        checkOutput("reset.ovf",     32'(ovf_a),   0);
        rst_n = 1'b1;

        $display("[TB] table vectors: single event and three back-to-back events");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].ev, vecs[i].en, vecs[i].clr);
            checkOutput($sformatf("vec%0d.pulse", i),   32'(pulse_a), vecs[i].exp_pulse);
            checkOutput($sformatf("vec%0d.pending", i), 32'(pend_a),  vecs[i].exp_pend);
            checkOutput($sformatf("vec%0d.busy", i),    32'(busy_a),  vecs[i].exp_busy);
            checkOutput($sformatf("vec%0d.ovf", i),     32'(ovf_a),   vecs[i].exp_ovf);
        end

        $display("[TB] saturation with en=0, then drain and clear overflow");
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            pulses += int'(pulse_b);
        end
        checkOutput("sat.pending_b", 32'(pend_b), 3);
        checkOutput("sat.ovf_b",     32'(ovf_b),  1);
        checkOutput("sat.no_pulse",  32'(pulses), 0);
        last = -1;
        bad  = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (pulse_b) begin
                if (last >= 0 && c - last != 4) bad++;
                last = c;
                pulses++;
            end
        end
        checkOutput("sat.pulse_count_b", 32'(pulses), 3);
        checkOutput("sat.spacing_b",     32'(bad),    0);
        checkOutput("sat.ovf_sticky_b",  32'(ovf_b),  1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("sat.ovf_cleared_b", 32'(ovf_b), 0);

        $display("[TB] event at full queue on the same cycle as a fire decision");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("full_dec.pending_pre", 32'(pend_b), 3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("full_dec.pending", 32'(pend_b),  3);
        checkOutput("full_dec.ovf",     32'(ovf_b),   0);
        checkOutput("full_dec.pulse",   32'(pulse_b), 1);
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);

        $display("[TB] asynchronous reset while waiting with two events queued");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rst_mid.pending_pre", 32'(pend_a), 2);
        checkOutput("rst_mid.busy_pre",    32'(busy_a), 1);
        event_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_mid.pulse",   32'(pulse_a), 0);
        checkOutput("rst_mid.pending", 32'(pend_a),  0);
        checkOutput("rst_mid.busy",    32'(busy_a),  0);
        checkOutput("rst_mid.ovf",     32'(ovf_a),   0);
        compareModel();
        @(posedge clk_src);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            pulses += int'(pulse_a);
        end
        checkOutput("rst_mid.no_pulse_after", 32'(pulses), 0);

        $display("[TB] GAP=2 burst of eight events");
        acc_before = m_acc[2];
        pulses = 0;
        last   = -1;
        bad    = 0;
        for (int c = 0; c < 38; c++) begin
            applyStimulus((c < 8) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            if (pulse_c) begin
                if (last >= 0 && c - last != 2) bad++;
                last = c;
                pulses++;
            end
        end
        checkOutput("gap2.pulse_count",   32'(pulses), 8);
        checkOutput("gap2.scoreboard",    32'(pulses), m_acc[2] - acc_before);
        checkOutput("gap2.spacing",       32'(bad),    0);
        applyStimulus(1'b0, 1'b1, 1'b1);

        $display("[TB] randomized traffic");
        n = 0;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom % 2), 1'(($urandom % 10) < 8), 1'(($urandom % 20) == 0));
            n++;
        end
        checkOutput("random.cycles", 32'(n), 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
